maze_round_ctrl: RTL and testbench

//  Game-round sequencer for the VGA maze game, clocked by the 1 Hz sec_clock.
//  - Snapshots LFSR wall patterns into stable maze registers at round start.
//  - Runs the round countdown, score and lives.
//  - Tells the player datapath when to respawn, and sequences win/lose/game-over.
//  - Replaces the ad-hoc timer/score/timer_reset logic in the top-level VGA module.

---
 rtl/maze_game_pkg.sv | 23 ++
 rtl/round_down_counter.sv | 38 +++
 rtl/maze_round_ctrl.sv | 168 ++++++++++++++++
 tb/tb_maze_round_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/maze_game_pkg.sv
// Shared types and defaults for the maze game round sequencer.
package maze_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4,
        ST_OVER = 3'd5
    } state_e;

    localparam int MAZE_W_DEF     = 50;
    localparam int ROUND_TIME_DEF = 49;
    localparam int LIVES_DEF      = 3;
    localparam int TIMER_W        = 8;
    localparam int LIVES_W        = 3;

    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] v);
        return (v == '0) ? v : v - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/round_down_counter.sv
// Loadable down counter that floors at zero; is_one_o flags the last counted cycle.
module round_down_counter #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         sec_clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         is_one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge sec_clock) begin
        if (!reset) begin
            count_q <= W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/maze_round_ctrl.sv
// Round sequencer for the VGA maze game: maze snapshot, countdown, score, lives
// and the win/lose/game-over flow, all on the 1 Hz sec_clock.
module maze_round_ctrl
    import maze_game_pkg::*;
#(
    parameter int MAZE_W     = MAZE_W_DEF,
    parameter int ROUND_TIME = ROUND_TIME_DEF,
    parameter int LIVES      = LIVES_DEF,
    parameter int WIN_HOLD   = 2,
    parameter int LOSE_HOLD  = 2,
    parameter int SCORE_W    = 16
) (
    input  logic               sec_clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               goal_hit,
    input  logic               wall_hit,
    input  logic [MAZE_W-1:0]  rand_h,
    input  logic [MAZE_W-1:0]  rand_v,
    output logic [MAZE_W-1:0]  maze_h,
    output logic [MAZE_W-1:0]  maze_v,
    output logic               maze_load,
    output logic               player_home,
    output logic [7:0]         timer,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               game_over,
    output logic [2:0]         state_o
);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [MAZE_W-1:0]    maze_h_q, maze_h_d;
    logic [MAZE_W-1:0]    maze_v_q, maze_v_d;
    logic                 maze_load_q;
    logic                 player_home_q;
    logic                 game_over_q;

    logic                 tmr_load, tmr_en, tmr_is_one;
    logic [TIMER_W-1:0]   tmr_val, tmr_cnt;
    logic                 hold_load, hold_en, hold_is_one, hold_done;
    logic [TIMER_W-1:0]   hold_val, hold_cnt;

    round_down_counter #(.W(TIMER_W), .RST_VAL(ROUND_TIME)) u_round_timer (
        .sec_clock  (sec_clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .count_o    (tmr_cnt),
        .is_one_o   (tmr_is_one)
    );

    round_down_counter #(.W(TIMER_W), .RST_VAL(0)) u_hold_timer (
        .sec_clock  (sec_clock),
        .reset      (reset),
        .load_i     (hold_load),
        .load_val_i (hold_val),
        .en_i       (hold_en),
        .count_o    (hold_cnt),
        .is_one_o   (hold_is_one)
    );

    // A zero hold length behaves like a single cycle instead of stalling forever.
    assign hold_done = hold_is_one || (hold_cnt == '0);

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        maze_h_d  = maze_h_q;
        maze_v_d  = maze_v_q;
        tmr_load  = 1'b0;
        tmr_val   = TIMER_W'(ROUND_TIME);
        tmr_en    = 1'b0;
        hold_load = 1'b0;
        hold_val  = TIMER_W'(WIN_HOLD);
        hold_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                maze_h_d = rand_h;
                maze_v_d = rand_v;
                tmr_load = 1'b1;
                state_d  = ST_PLAY;
            end
            ST_PLAY: begin
                if (!pause) begin
                    if (goal_hit) begin
                        score_d   = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                        hold_load = 1'b1;
                        state_d   = ST_WIN;
                    end else if (wall_hit || tmr_is_one) begin
                        tmr_en    = !wall_hit;
                        lives_d   = lives_dec(lives_q);
                        hold_load = 1'b1;
                        hold_val  = TIMER_W'(LOSE_HOLD);
                        state_d   = ST_LOSE;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            end
            ST_WIN: begin
                hold_en = 1'b1;
                if (hold_done) state_d = ST_LOAD;
            end
            ST_LOSE: begin
                hold_en = 1'b1;
                if (hold_done) begin
                    tmr_load = 1'b1;
                    if (lives_q == '0) begin
                        tmr_val = '0;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_d = '0;
                    lives_d = LIVES_W'(LIVES);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sec_clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            score_q       <= '0;
            lives_q       <= LIVES_W'(LIVES);
            maze_h_q      <= '1;
            maze_v_q      <= '1;
            maze_load_q   <= 1'b0;
            player_home_q <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            maze_h_q      <= maze_h_d;
            maze_v_q      <= maze_v_d;
            maze_load_q   <= (state_q == ST_LOAD);
            player_home_q <= (state_d != ST_PLAY);
            game_over_q   <= (state_d == ST_OVER);
        end
    end

    assign maze_h      = maze_h_q;
    assign maze_v      = maze_v_q;
    assign maze_load   = maze_load_q;
    assign player_home = player_home_q;
    assign timer       = tmr_cnt;
    assign score       = score_q;
    assign lives       = lives_q;
    assign game_over   = game_over_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_maze_round_ctrl.sv
// Directed bench for maze_round_ctrl: expected snapshots queued per step, compared after each edge.
module tb_maze_round_ctrl;

    localparam int MAZE_W = 50;

    logic              sec_clock = 1'b0;
    logic              reset, start, pause, goal_hit, wall_hit;
    logic [MAZE_W-1:0] rand_h, rand_v;
    logic [MAZE_W-1:0] maze_h, maze_v;
    logic              maze_load, player_home, game_over;
    logic [7:0]        timer;
    logic [15:0]       score;
    logic [2:0]        lives;
    logic [2:0]        state_o;

    logic [MAZE_W-1:0] ones, h1, v1, h2;

    maze_round_ctrl dut (
        .sec_clock   (sec_clock),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .goal_hit    (goal_hit),
        .wall_hit    (wall_hit),
        .rand_h      (rand_h),
        .rand_v      (rand_v),
        .maze_h      (maze_h),
        .maze_v      (maze_v),
        .maze_load   (maze_load),
        .player_home (player_home),
        .timer       (timer),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over),
        .state_o     (state_o)
    );

    always #5 sec_clock = ~sec_clock;

    typedef struct {
        string tag;
        int    st;
        int    tmr;
        int    sc;
        int    lv;
        int    ml;
        int    ph;
        int    go;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input int st, input int tmr, input int sc,
                        input int lv, input int ml, input int ph, input int go);
        exp_t e;
        e.tag = tag; e.st = st; e.tmr = tmr; e.sc = sc;
        e.lv = lv; e.ml = ml; e.ph = ph; e.go = go;
        sb_q.push_back(e);
        @(posedge sec_clock);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, ".state"},       64'(state_o),     64'(e.st));
        chk({e.tag, ".timer"},       64'(timer),       64'(e.tmr));
        chk({e.tag, ".score"},       64'(score),       64'(e.sc));
        chk({e.tag, ".lives"},       64'(lives),       64'(e.lv));
        chk({e.tag, ".maze_load"},   64'(maze_load),   64'(e.ml));
        chk({e.tag, ".player_home"}, 64'(player_home), 64'(e.ph));
        chk({e.tag, ".game_over"},   64'(game_over),   64'(e.go));
    endtask

    // Unpaused, hit-free PLAY cycles from timer value 'from' down to 'to'.
    task automatic play_to(input int from, input int to, input int sc, input int lv);
        for (int t = from - 1; t >= to; t--) begin
            step($sformatf("run%0d", t), 2, t, sc, lv, 0, 0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ones = '1;
        h1   = 50'h2AAAA_AAAA_AAAA;
        v1   = 50'h1_2345_6789_ABCD;
        h2   = 50'h0F0F_0F0F_0F0F;
        reset = 1'b0; start = 1'b0; pause = 1'b0;
        goal_hit = 1'b0; wall_hit = 1'b0;
        rand_h = h1; rand_v = v1;

        step("rst", 0, 49, 0, 3, 0, 1, 0);
        chk("rst.maze_h", 64'(maze_h), 64'(ones));
        chk("rst.maze_v", 64'(maze_v), 64'(ones));
        reset = 1'b1;

        start = 1'b1;
        step("start", 1, 49, 0, 3, 0, 1, 0);
        start = 1'b0;
        step("load", 2, 49, 0, 3, 1, 0, 0);
        chk("load.maze_h", 64'(maze_h), 64'(h1));
        chk("load.maze_v", 64'(maze_v), 64'(v1));
        rand_h = ~h1; rand_v = '0;
        step("keep", 2, 48, 0, 3, 0, 0, 0);
        chk("keep.maze_h", 64'(maze_h), 64'(h1));
        chk("keep.maze_v", 64'(maze_v), 64'(v1));

        play_to(48, 1, 0, 3);
        step("timeout", 4, 0, 0, 2, 0, 1, 0);
        step("lose_hold", 4, 0, 0, 2, 0, 1, 0);
        step("respawn", 2, 49, 0, 2, 0, 0, 0);
        chk("respawn.maze_h", 64'(maze_h), 64'(h1));

        play_to(49, 30, 0, 2);
        pause = 1'b1; goal_hit = 1'b1; wall_hit = 1'b1; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("pause%0d", i), 2, 30, 0, 2, 0, 0, 0);
        end
        pause = 1'b0; goal_hit = 1'b0; wall_hit = 1'b0; start = 1'b0;

        play_to(30, 10, 0, 2);
        rand_h = h2;
        goal_hit = 1'b1; wall_hit = 1'b1;
        step("goalwall", 3, 10, 1, 2, 0, 1, 0);
        goal_hit = 1'b0; wall_hit = 1'b0;
        step("win_hold", 3, 10, 1, 2, 0, 1, 0);
        step("win_load", 1, 10, 1, 2, 0, 1, 0);
        step("newmaze", 2, 49, 1, 2, 1, 0, 0);
        chk("newmaze.maze_h", 64'(maze_h), 64'(h2));

        goal_hit = 1'b1;
        step("win2", 3, 49, 2, 2, 0, 1, 0);
        goal_hit = 1'b0;
        step("win2_hold", 3, 49, 2, 2, 0, 1, 0);
        step("win2_load", 1, 49, 2, 2, 0, 1, 0);
        step("win2_play", 2, 49, 2, 2, 1, 0, 0);
        goal_hit = 1'b1;
        step("win3", 3, 49, 3, 2, 0, 1, 0);
        goal_hit = 1'b0;
        step("win3_hold", 3, 49, 3, 2, 0, 1, 0);
        step("win3_load", 1, 49, 3, 2, 0, 1, 0);
        step("win3_play", 2, 49, 3, 2, 1, 0, 0);

        play_to(49, 20, 3, 2);
        reset = 1'b0;
        step("midrst", 0, 49, 0, 3, 0, 1, 0);
        chk("midrst.maze_h", 64'(maze_h), 64'(ones));
        reset = 1'b1;

        start = 1'b1;
        step("g2_start", 1, 49, 0, 3, 0, 1, 0);
        start = 1'b0;
        step("g2_play", 2, 49, 0, 3, 1, 0, 0);
        goal_hit = 1'b1;
        step("g2_win", 3, 49, 1, 3, 0, 1, 0);
        goal_hit = 1'b0;
        step("g2_win_hold", 3, 49, 1, 3, 0, 1, 0);
        step("g2_load", 1, 49, 1, 3, 0, 1, 0);
        step("g2_play2", 2, 49, 1, 3, 1, 0, 0);

        wall_hit = 1'b1;
        step("wall1", 4, 49, 1, 2, 0, 1, 0);
        wall_hit = 1'b0;
        step("wall1_hold", 4, 49, 1, 2, 0, 1, 0);
        step("wall1_play", 2, 49, 1, 2, 0, 0, 0);
        wall_hit = 1'b1;
        step("wall2", 4, 49, 1, 1, 0, 1, 0);
        wall_hit = 1'b0;
        step("wall2_hold", 4, 49, 1, 1, 0, 1, 0);
        step("wall2_play", 2, 49, 1, 1, 0, 0, 0);
        wall_hit = 1'b1;
        step("wall3", 4, 49, 1, 0, 0, 1, 0);
        wall_hit = 1'b0; start = 1'b1;
        step("wall3_hold", 4, 49, 1, 0, 0, 1, 0);
        start = 1'b0;
        step("over", 5, 0, 1, 0, 0, 1, 1);
        step("over_hold", 5, 0, 1, 0, 0, 1, 1);
        start = 1'b1;
        step("restart", 1, 0, 0, 3, 0, 1, 0);
        start = 1'b0;
        step("restart_play", 2, 49, 0, 3, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
